uart_receiver: RTL and testbench

- Receives serial data in 8N1 format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); the line idles high.
- Oversamples the line on a clock enable, samples each bit at its centre, and presents each received byte with a one-cycle valid strobe.
- Sits alongside the UART transmitter. It shares the same clk_in and the same 16x-baud clk_en from the clock wizard, and feeds received bytes to the control/setpoint logic.

---
 rtl/uart_receiver.sv | 173 +++++++++++++++++
 tb/tb_uart_receiver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// 8N1 serial receiver: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
// The line idles high. rx_in is synchronised, oversampled on clk_en and each bit
// is sampled at its centre. Good frames update rx_data with a one-cycle
// rx_valid strobe; a stop bit sampled low gives a one-cycle frame_err strobe.
//
// Parameters
//   OVERSAMPLE  : clk_en ticks per bit period (even, >= 4)
//   SYNC_STAGES : flops in the rx_in synchroniser (>= 2)
//
// Ports
//   clk_in    in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   clk_en    in   oversample tick, one clk_in cycle wide
//   rx_in     in   asynchronous serial line
//   rx_data   out  [7:0] last correctly framed byte (held until the next one)
//   rx_valid  out  one-cycle pulse when rx_data has just been updated
//   frame_err out  one-cycle pulse when the stop bit was sampled low
//   busy_o    out  high whenever the receiver is not idle
//
// Handshake: rx_valid is a pure strobe with no ready/backpressure. The
// consumer must take rx_data on the rx_valid cycle or before the next frame
// completes; rx_data itself stays stable between good frames.
// -----------------------------------------------------------------------------
module uart_receiver #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       clk_en,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   // Start bit is checked half a bit after the falling edge; data and stop
   // bits a whole bit after the previous centre.
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [TW-1:0]          tick_q, tick_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shreg_q, shreg_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   busy_q, busy_d;
   logic                   rx_s;

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
      state_d     = state_q;
      tick_d      = tick_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      if (clk_en) begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  tick_d  = '0;
                  state_d = S_START;
               end
            end
            S_START: begin
               if (tick_q == TICK_MID) begin
                  // A line back high at the start centre was a glitch.
                  if (rx_s) begin
                     state_d = S_IDLE;
                  end else begin
                     tick_d  = '0;
                     bit_d   = 3'd0;
                     state_d = S_DATA;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_DATA: begin
               if (tick_q == TICK_END) begin
                  shreg_d = {rx_s, shreg_q[7:1]};
                  tick_d  = '0;
                  if (bit_q == 3'd7) begin
                     state_d = S_STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_STOP: begin
               // Leaving mid stop bit lets a back-to-back start edge be seen.
               if (tick_q == TICK_END) begin
                  if (rx_s) begin
                     rx_data_d  = shreg_q;
                     rx_valid_d = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_BREAK;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_BREAK: begin
               // Wait for the line to go high so a held-low line cannot
               // look like a fresh start bit.
               if (rx_s) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync_q      <= '1;
         state_q     <= S_IDLE;
         tick_q      <= '0;
         bit_q       <= 3'd0;
         shreg_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Drives 8N1 frames onto rx_in with bit lengths expressed in clk_in cycles, so
// the bit rate can be skewed against the receiver's clk_en rate. The reference
// model is the frame list itself: every frame sent with a high stop bit pushes
// its byte onto exp_q, every frame sent with a low stop bit adds one expected
// frame error. A negedge monitor pops exp_q on each rx_valid.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       clk_en;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy_o;

   uart_receiver #(
      .OVERSAMPLE (16),
      .SYNC_STAGES(2)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .clk_en   (clk_en),
      .rx_in    (rx_in),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy_o   (busy_o)
   );

   // ---------------- clock / reset / clk_en ----------------
   always #5 clk_in = ~clk_in;

   int en_period = 1;
   int en_cnt    = 0;

   initial begin
      clk_en = 1'b0;
      forever begin
         @(posedge clk_in);
         #1;
         if (en_cnt >= en_period - 1) begin
            clk_en = 1'b1;
            en_cnt = 0;
         end else begin
            clk_en = 1'b0;
            en_cnt++;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         exp_fe    = 0;
   int         seen_fe   = 0;
   int         errors    = 0;
   int         checks    = 0;
   logic       prev_valid = 1'b0;
   logic       prev_fe    = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (rx_valid === 1'b1) begin
         check_eq("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
         check_eq("valid_not_with_ferr", {31'd0, frame_err}, 32'd0);
         check_eq("valid_was_expected", {31'd0, exp_q.size() > 0}, 32'd1);
         if (exp_q.size() > 0) begin
            check_eq("rx_data_on_valid", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
         end
      end
      if (frame_err === 1'b1) begin
         seen_fe++;
         check_eq("ferr_single_cycle", {31'd0, prev_fe}, 32'd0);
      end
      prev_valid = rx_valid;
      prev_fe    = frame_err;
   end

   // ---------------- driver tasks ----------------
   task automatic hold(input logic v, input int cycles);
      rx_in = v;
      repeat (cycles) @(posedge clk_in);
      #1;
   endtask

   // Expectations are queued before the stop bit: the receiver reports at the
   // stop bit centre, while the stop bit is still on the line.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
      hold(1'b0, bc);
      for (int i = 0; i < 8; i++) hold(b[i], bc);
      if (stop) begin
         exp_q.push_back(b);
         last_good = b;
      end else begin
         exp_fe++;
      end
      hold(stop, bc);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy_o !== 1'b0 || exp_q.size() != 0) && n < 5000) begin
         @(posedge clk_in);
         #1;
         n++;
      end
      check_eq(tag, {31'd0, n < 5000}, 32'd1);
   endtask

   task automatic check_quiet(input string pfx);
      check_eq({pfx, "_exp_q_empty"}, exp_q.size(), 32'd0);
      check_eq({pfx, "_ferr_count"}, seen_fe, exp_fe);
      check_eq({pfx, "_rx_data"}, {24'd0, rx_data}, {24'd0, last_good});
      check_eq({pfx, "_busy"}, {31'd0, busy_o}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_rx_data"}, {24'd0, rx_data}, 32'd0);
      check_eq({pfx, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
      check_eq({pfx, "_frame_err"}, {31'd0, frame_err}, 32'd0);
      check_eq({pfx, "_busy"}, {31'd0, busy_o}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         bc;
      logic [7:0] rb;
      logic       bad;

      reset = 1'b1;
      rx_in = 1'b1;
      repeat (5) @(posedge clk_in);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      hold(1'b1, 40);

      // Single byte, clk_en every cycle.
      en_period = 1;
      send_frame(8'hA5, 1'b1, 16);
      hold(1'b1, 16);
      wait_idle("t1_idle");
      check_quiet("t1");

      // Back-to-back 0x00 then 0xFF, clk_en every 4th cycle.
      en_period = 4;
      hold(1'b1, 64);
      send_frame(8'h00, 1'b1, 64);
      send_frame(8'hFF, 1'b1, 64);
      hold(1'b1, 64);
      wait_idle("t2_idle");
      check_quiet("t2");

      // False start: 5 ticks low.
      en_period = 2;
      hold(1'b1, 32);
      hold(1'b0, 10);
      check_eq("t3_busy_during", {31'd0, busy_o}, 32'd1);
      hold(1'b1, 32);
      wait_idle("t3_idle");
      check_quiet("t3");

      // Good frame, bad stop bit, line held low, then recovery.
      en_period = 1;
      send_frame(8'hA5, 1'b1, 16);
      hold(1'b1, 16);
      send_frame(8'h3C, 1'b0, 16);
      hold(1'b0, 40);
      check_eq("t4_busy_in_break", {31'd0, busy_o}, 32'd1);
      check_eq("t4_ferr_count", seen_fe, exp_fe);
      check_eq("t4_rx_data_kept", {24'd0, rx_data}, 32'hA5);
      hold(1'b1, 32);
      check_eq("t4_busy_after_break", {31'd0, busy_o}, 32'd0);
      send_frame(8'h5A, 1'b1, 16);
      hold(1'b1, 16);
      wait_idle("t4_idle");
      check_quiet("t4");

      // Reset during data bit 3 of 0x81, then 0x7E.
      hold(1'b0, 16);
      hold(1'b1, 16);
      hold(1'b0, 16);
      hold(1'b0, 16);
      hold(1'b0, 8);
      reset = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      check_reset_outputs("t5_reset");
      last_good = 8'h00;
      reset = 1'b0;
      hold(1'b1, 32);
      check_reset_outputs("t5_after");
      send_frame(8'h7E, 1'b1, 16);
      hold(1'b1, 16);
      wait_idle("t5_idle");
      check_quiet("t5");

      // Skewed bit rate: 15.5 and 16.5 ticks per bit.
      en_period = 2;
      hold(1'b1, 32);
      send_frame(8'h55, 1'b1, 31);
      hold(1'b1, 40);
      send_frame(8'h55, 1'b1, 33);
      hold(1'b1, 40);
      wait_idle("t6_idle");
      check_quiet("t6");

      // Random frames, random tick rate, occasional bad stop bit.
      for (int k = 0; k < 20; k++) begin
         en_period = $urandom_range(1, 4);
         hold(1'b1, 16 * en_period);
         bc  = 16 * en_period;
         rb  = 8'($urandom);
         bad = ($urandom_range(0, 5) == 0);
         send_frame(rb, !bad, bc);
         hold(1'b1, bc + $urandom_range(0, 20));
      end
      wait_idle("rand_idle");
      check_quiet("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
